// File: rtl/core_pkg.sv
// Shared definitions for the fetch/redirect path: branch codes, FSM state, PC width.
package core_pkg;

  localparam int unsigned PC_W = 32;
  localparam logic [PC_W-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  // Conditional-branch funct3 encodings.
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } state_e;

endpackage

// File: rtl/branch_cond.sv
// Combinational branch-condition evaluator; reserved encodings resolve to not-taken.
module branch_cond
  import core_pkg::*;
(
  input  logic [2:0]      funct3_i,
  input  logic [PC_W-1:0] rs1_i,
  input  logic [PC_W-1:0] rs2_i,
  output logic            cond_o
);

  logic eq;
  logic lt_s;
  logic lt_u;

  assign eq   = (rs1_i == rs2_i);
  assign lt_s = ($signed(rs1_i) < $signed(rs2_i));
  assign lt_u = (rs1_i < rs2_i);

  // Decode funct3 into the selected comparison result.
  always_comb begin
    cond_o = 1'b0;
    case (funct3_i)
      F3_BEQ:  cond_o = eq;
      F3_BNE:  cond_o = ~eq;
      F3_BLT:  cond_o = lt_s;
      F3_BGE:  cond_o = ~lt_s;
      F3_BLTU: cond_o = lt_u;
      F3_BGEU: cond_o = ~lt_u;
      default: cond_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/pc_redirect_unit.sv
// Fetch PC owner: resolves EX branches/jumps, redirects the PC, flushes IF/ID and counts branches.
module pc_redirect_unit
  import core_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC     = RESET_PC_DEFAULT,
  parameter int unsigned     FLUSH_CYCLES = 2,
  parameter int unsigned     CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             ex_valid,
  input  logic             ex_is_branch,
  input  logic             ex_is_jump,
  input  logic [2:0]       ex_funct3,
  input  logic [PC_W-1:0]  ex_pc,
  input  logic [PC_W-1:0]  ex_rs1,
  input  logic [PC_W-1:0]  ex_rs2,
  input  logic [PC_W-1:0]  ex_imm,
  input  logic [PC_W-1:0]  ex_jump_target,
  output logic [PC_W-1:0]  pc,
  output logic             flush,
  output logic             taken,
  output logic             misalign_err,
  output logic [CNT_W-1:0] branch_cnt,
  output logic [CNT_W-1:0] taken_cnt
);

  state_e           state_q, state_d;
  logic [2:0]       fcnt_q, fcnt_d;
  logic [PC_W-1:0]  pc_q, pc_d;
  logic             taken_q, taken_d;
  logic             mis_q, mis_d;
  logic [CNT_W-1:0] branch_cnt_q, branch_cnt_d;
  logic [CNT_W-1:0] taken_cnt_q, taken_cnt_d;

  logic            cond;
  logic            accept;
  logic            br_resolved;
  logic            br_taken;
  logic            redirect;
  logic [PC_W-1:0] target;

  branch_cond u_branch_cond (
    .funct3_i (ex_funct3),
    .rs1_i    (ex_rs1),
    .rs2_i    (ex_rs2),
    .cond_o   (cond)
  );

  // EX is only honoured in RUN; a jump overrides a simultaneous branch flag.
  assign accept      = (state_q == RUN) && ex_valid;
  assign br_resolved = accept && ex_is_branch && !ex_is_jump;
  assign br_taken    = br_resolved && cond;
  assign redirect    = accept && (ex_is_jump || (ex_is_branch && cond));
  assign target      = ex_is_jump ? ex_jump_target : (ex_pc + ex_imm);

  // Next-state logic for the FSM, PC, flush counter and sticky error.
  always_comb begin
    state_d = state_q;
    fcnt_d  = fcnt_q;
    pc_d    = pc_q;
    taken_d = 1'b0;
    mis_d   = mis_q;
    unique case (state_q)
      RUN: begin
        if (redirect) begin
          pc_d    = {target[PC_W-1:2], 2'b00};
          mis_d   = mis_q | target[1];
          taken_d = 1'b1;
          fcnt_d  = 3'(FLUSH_CYCLES);
          state_d = FLUSH;
        end else if (!stall) begin
          pc_d = pc_q + 32'd4;
        end
      end
      FLUSH: begin
        fcnt_d = fcnt_q - 3'd1;
        if (!stall) pc_d = pc_q + 32'd4;
        if (fcnt_q <= 3'd1) state_d = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  // Saturating statistics counters, independent of stall.
  always_comb begin
    branch_cnt_d = branch_cnt_q;
    taken_cnt_d  = taken_cnt_q;
    if (br_resolved && (branch_cnt_q != '1)) branch_cnt_d = branch_cnt_q + 1'b1;
    if (br_taken && (taken_cnt_q != '1))     taken_cnt_d  = taken_cnt_q + 1'b1;
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= RUN;
      fcnt_q       <= 3'd0;
      pc_q         <= RESET_PC;
      taken_q      <= 1'b0;
      mis_q        <= 1'b0;
      branch_cnt_q <= '0;
      taken_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      fcnt_q       <= fcnt_d;
      pc_q         <= pc_d;
      taken_q      <= taken_d;
      mis_q        <= mis_d;
      branch_cnt_q <= branch_cnt_d;
      taken_cnt_q  <= taken_cnt_d;
    end
  end

  assign pc           = pc_q;
  assign flush        = (state_q == FLUSH);
  assign taken        = taken_q;
  assign misalign_err = mis_q;
  assign branch_cnt   = branch_cnt_q;
  assign taken_cnt    = taken_cnt_q;

endmodule

// File: tb/tb_pc_redirect_unit.sv
// Directed self-checking bench for pc_redirect_unit.
module tb_pc_redirect_unit;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        ex_valid;
  logic        ex_is_branch;
  logic        ex_is_jump;
  logic [2:0]  ex_funct3;
  logic [31:0] ex_pc;
  logic [31:0] ex_rs1;
  logic [31:0] ex_rs2;
  logic [31:0] ex_imm;
  logic [31:0] ex_jump_target;
  logic [31:0] pc;
  logic        flush;
  logic        taken;
  logic        misalign_err;
  logic [15:0] branch_cnt;
  logic [15:0] taken_cnt;

  int checks = 0;
  int errors = 0;

  pc_redirect_unit #(
    .RESET_PC     (32'h0000_0078),
    .FLUSH_CYCLES (2),
    .CNT_W        (16)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .stall          (stall),
    .ex_valid       (ex_valid),
    .ex_is_branch   (ex_is_branch),
    .ex_is_jump     (ex_is_jump),
    .ex_funct3      (ex_funct3),
    .ex_pc          (ex_pc),
    .ex_rs1         (ex_rs1),
    .ex_rs2         (ex_rs2),
    .ex_imm         (ex_imm),
    .ex_jump_target (ex_jump_target),
    .pc             (pc),
    .flush          (flush),
    .taken          (taken),
    .misalign_err   (misalign_err),
    .branch_cnt     (branch_cnt),
    .taken_cnt      (taken_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance one cycle; sampling and driving happen 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    ex_valid       = 1'b0;
    ex_is_branch   = 1'b0;
    ex_is_jump     = 1'b0;
    ex_funct3      = 3'b000;
    ex_pc          = 32'h0;
    ex_rs1         = 32'h0;
    ex_rs2         = 32'h0;
    ex_imm         = 32'h0;
    ex_jump_target = 32'h0;
  endtask

  task automatic branch(input logic [2:0] f3, input logic [31:0] bpc, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] imm);
    ex_valid     = 1'b1;
    ex_is_branch = 1'b1;
    ex_is_jump   = 1'b0;
    ex_funct3    = f3;
    ex_pc        = bpc;
    ex_rs1       = a;
    ex_rs2       = b;
    ex_imm       = imm;
  endtask

  task automatic do_reset();
    idle();
    stall = 1'b0;
    rst   = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    stall = 1'b0;
    rst   = 1'b1;
    #2;
    checks++; if (pc !== 32'h78) begin errors++; $display("FAIL reset_pc: got %h exp %h", pc, 32'h78); end
    checks++; if (flush !== 1'b0) begin errors++; $display("FAIL reset_flush: got %b exp 0", flush); end
    checks++; if (taken !== 1'b0) begin errors++; $display("FAIL reset_taken: got %b exp 0", taken); end
    checks++; if (misalign_err !== 1'b0) begin errors++; $display("FAIL reset_mis: got %b exp 0", misalign_err); end
    checks++; if (branch_cnt !== 16'd0 || taken_cnt !== 16'd0) begin errors++;
      $display("FAIL reset_cnt: got %0d/%0d exp 0/0", branch_cnt, taken_cnt); end
    tick();
    rst = 1'b0;
  endtask

  task automatic test_bne_taken();
    do_reset();
    branch(3'b001, 32'h78, 32'h5, 32'h3, 32'h14);
    tick();
    idle();
    checks++; if (pc !== 32'h8C) begin errors++; $display("FAIL bne_t_pc: got %h exp %h", pc, 32'h8C); end
    checks++; if (taken !== 1'b1) begin errors++; $display("FAIL bne_t_taken: got %b exp 1", taken); end
    checks++; if (flush !== 1'b1) begin errors++; $display("FAIL bne_t_flush1: got %b exp 1", flush); end
    checks++; if (branch_cnt !== 16'd1 || taken_cnt !== 16'd1) begin errors++;
      $display("FAIL bne_t_cnt: got %0d/%0d exp 1/1", branch_cnt, taken_cnt); end
    tick();
    checks++; if (taken !== 1'b0) begin errors++; $display("FAIL bne_t_pulse: got %b exp 0", taken); end
    checks++; if (flush !== 1'b1 || pc !== 32'h90) begin errors++;
      $display("FAIL bne_t_flush2: got flush=%b pc=%h exp flush=1 pc=00000090", flush, pc); end
    tick();
    checks++; if (flush !== 1'b0 || pc !== 32'h94) begin errors++;
      $display("FAIL bne_t_flush_end: got flush=%b pc=%h exp flush=0 pc=00000094", flush, pc); end
  endtask

  task automatic test_bne_not_taken();
    do_reset();
    branch(3'b001, 32'h78, 32'h7, 32'h7, 32'h14);
    tick();
    idle();
    checks++; if (pc !== 32'h7C) begin errors++; $display("FAIL bne_nt_pc: got %h exp %h", pc, 32'h7C); end
    checks++; if (flush !== 1'b0 || taken !== 1'b0) begin errors++;
      $display("FAIL bne_nt_flags: got flush=%b taken=%b exp 0/0", flush, taken); end
    checks++; if (branch_cnt !== 16'd1 || taken_cnt !== 16'd0) begin errors++;
      $display("FAIL bne_nt_cnt: got %0d/%0d exp 1/0", branch_cnt, taken_cnt); end
  endtask

  task automatic test_signed_unsigned();
    do_reset();
    // blt: -1 < 1 signed -> taken to 0x78+0x8
    branch(3'b100, 32'h78, 32'hFFFF_FFFF, 32'h1, 32'h8);
    tick();
    idle();
    checks++; if (pc !== 32'h80 || taken !== 1'b1) begin errors++;
      $display("FAIL blt_signed: got pc=%h taken=%b exp pc=00000080 taken=1", pc, taken); end
    tick();
    tick();
    // bltu: 0xFFFFFFFF < 1 unsigned is false -> sequential
    branch(3'b110, 32'h300, 32'hFFFF_FFFF, 32'h1, 32'h8);
    tick();
    idle();
    checks++; if (pc !== 32'h8C || taken !== 1'b0) begin errors++;
      $display("FAIL bltu_unsigned: got pc=%h taken=%b exp pc=0000008c taken=0", pc, taken); end
    branch(3'b111, 32'h200, 32'hFFFF_FFFF, 32'h1, 32'h40);
    tick();
    idle();
    checks++; if (pc !== 32'h240 || taken !== 1'b1) begin errors++;
      $display("FAIL bgeu_unsigned: got pc=%h taken=%b exp pc=00000240 taken=1", pc, taken); end
    checks++; if (branch_cnt !== 16'd3 || taken_cnt !== 16'd2) begin errors++;
      $display("FAIL su_cnt: got %0d/%0d exp 3/2", branch_cnt, taken_cnt); end
    tick();
    tick();
  endtask

  task automatic test_stall_redirect();
    do_reset();
    stall = 1'b1;
    branch(3'b000, 32'h78, 32'h9, 32'h9, 32'h88);
    tick();
    idle();
    checks++; if (pc !== 32'h100 || flush !== 1'b1) begin errors++;
      $display("FAIL stall_redir: got pc=%h flush=%b exp pc=00000100 flush=1", pc, flush); end
    tick();
    checks++; if (pc !== 32'h100 || flush !== 1'b1) begin errors++;
      $display("FAIL stall_flush2: got pc=%h flush=%b exp pc=00000100 flush=1", pc, flush); end
    tick();
    checks++; if (pc !== 32'h100 || flush !== 1'b0) begin errors++;
      $display("FAIL stall_flush_end: got pc=%h flush=%b exp pc=00000100 flush=0", pc, flush); end
    stall = 1'b0;
    tick();
    checks++; if (pc !== 32'h104) begin errors++; $display("FAIL stall_release: got %h exp %h", pc, 32'h104); end
  endtask

  task automatic test_flush_wrap_misalign();
    do_reset();
    // Jump with a true branch flag alongside: jump wins, branch not counted.
    branch(3'b000, 32'h78, 32'h1, 32'h1, 32'h10);
    ex_is_jump     = 1'b1;
    ex_jump_target = 32'hFFFF_FFFE;
    tick();
    idle();
    checks++; if (pc !== 32'hFFFF_FFFC || misalign_err !== 1'b1) begin errors++;
      $display("FAIL jump_mis: got pc=%h mis=%b exp pc=fffffffc mis=1", pc, misalign_err); end
    checks++; if (branch_cnt !== 16'd0 || taken_cnt !== 16'd0) begin errors++;
      $display("FAIL jump_cnt: got %0d/%0d exp 0/0", branch_cnt, taken_cnt); end
    stall = 1'b1;
    branch(3'b001, 32'h400, 32'h1, 32'h2, 32'h10);
    tick();
    idle();
    checks++; if (pc !== 32'hFFFF_FFFC || taken !== 1'b0 || flush !== 1'b1) begin errors++;
      $display("FAIL flush_squash: got pc=%h taken=%b flush=%b exp fffffffc/0/1", pc, taken, flush); end
    checks++; if (branch_cnt !== 16'd0 || taken_cnt !== 16'd0) begin errors++;
      $display("FAIL squash_cnt: got %0d/%0d exp 0/0", branch_cnt, taken_cnt); end
    tick();
    checks++; if (flush !== 1'b0) begin errors++; $display("FAIL squash_flush_end: got %b exp 0", flush); end
    stall = 1'b0;
    tick();
    checks++; if (pc !== 32'h0) begin errors++; $display("FAIL pc_wrap: got %h exp %h", pc, 32'h0); end
    checks++; if (misalign_err !== 1'b1) begin errors++; $display("FAIL mis_sticky: got %b exp 1", misalign_err); end
  endtask

  task automatic test_async_reset();
    do_reset();
    // bne taken to 0x102: misaligned target, counters both become 1.
    branch(3'b001, 32'h78, 32'h1, 32'h2, 32'h8A);
    tick();
    idle();
    checks++; if (pc !== 32'h100 || flush !== 1'b1 || misalign_err !== 1'b1) begin errors++;
      $display("FAIL pre_rst: got pc=%h flush=%b mis=%b exp 00000100/1/1", pc, flush, misalign_err); end
    #2;
    rst = 1'b1;
    #1;
    checks++; if (pc !== 32'h78 || flush !== 1'b0 || taken !== 1'b0) begin errors++;
      $display("FAIL async_rst: got pc=%h flush=%b taken=%b exp 00000078/0/0", pc, flush, taken); end
    checks++; if (misalign_err !== 1'b0 || branch_cnt !== 16'd0 || taken_cnt !== 16'd0) begin errors++;
      $display("FAIL async_rst_stat: got mis=%b cnt=%0d/%0d exp 0 0/0", misalign_err, branch_cnt,
               taken_cnt); end
    tick();
    rst = 1'b0;
    tick();
    checks++; if (pc !== 32'h7C || flush !== 1'b0) begin errors++;
      $display("FAIL post_rst_run: got pc=%h flush=%b exp 0000007c/0", pc, flush); end
  endtask

  initial begin
    rst   = 1'b1;
    stall = 1'b0;
    idle();
    test_reset();
    test_bne_taken();
    test_bne_not_taken();
    test_signed_unsigned();
    test_stall_redirect();
    test_flush_wrap_misalign();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
